// File: rtl/serial_deser_if.sv
// Bus bundle for serial_deser: serial bit input, word output handshake and status.
// The slave modport is the deserializer; the master modport is the bit source and word consumer.
interface serial_deser_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overflow;
  logic             clear_ovf;

  modport master (
    output bit_in, bit_valid, word_ready, clear_ovf,
    input  word_out, word_valid, bit_cnt, overflow
  );

  modport slave (
    input  bit_in, bit_valid, word_ready, clear_ovf,
    output word_out, word_valid, bit_cnt, overflow
  );
endinterface

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer with a one-entry valid/ready output buffer
// and a sticky overflow flag for words dropped under backpressure.
module serial_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  serial_deser_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt, word_q;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             complete, load, drop;

  assign complete = bus.bit_valid && (cnt == CW'(WIDTH - 1));

  // Shift direction decides which end of the word the first bit lands in.
  always_comb begin
    if (MSB_FIRST) sr_nxt = {sr[WIDTH-2:0], bus.bit_in};
    else           sr_nxt = {bus.bit_in, sr[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          state_nxt = FULL;
          load      = 1'b1;
        end
      end
      FULL: begin
        if (complete) begin
          if (bus.word_ready) load = 1'b1;
          else                drop = 1'b1;
        end else if (bus.word_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (bus.bit_valid) begin
      sr  <= sr_nxt;
      cnt <= complete ? '0 : cnt + CW'(1);
    end
  end

  // word_out only moves on a load, so it is stable under backpressure.
  always_ff @(posedge clk) begin
    if (reset)     word_q <= '0;
    else if (load) word_q <= sr_nxt;
  end

  // A drop on the same edge as clear_ovf leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset)              ovf <= 1'b0;
    else if (drop)          ovf <= 1'b1;
    else if (bus.clear_ovf) ovf <= 1'b0;
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = (state == FULL);
  assign bus.bit_cnt    = cnt;
  assign bus.overflow   = ovf;
endmodule

// File: tb/tb_serial_deser.sv
// Randomized scoreboard bench for serial_deser: MSB-first and LSB-first instances share
// one stimulus stream and are checked against a queue-based reference model.
module tb_serial_deser;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bi = 1'b0, bv = 1'b0, rdy = 1'b0, clr = 1'b0;
  int   checks = 0, failures = 0;

  always #5 clk = ~clk;

  serial_deser_if #(.WIDTH(W)) if_m ();
  serial_deser_if #(.WIDTH(W)) if_l ();

  assign if_m.bit_in = bi;  assign if_m.bit_valid = bv;
  assign if_m.word_ready = rdy; assign if_m.clear_ovf = clr;
  assign if_l.bit_in = bi;  assign if_l.bit_valid = bv;
  assign if_l.word_ready = rdy; assign if_l.clear_ovf = clr;

  serial_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(if_m.slave));
  serial_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(if_l.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // Reference model: bits gathered in a queue, word built by plain indexing,
  // buffer tracked as "holds a word or not".
  logic           bq[$];
  logic [W-1:0]   exp_m[$], exp_l[$];
  logic [W-1:0]   m_wm, m_wl;
  bit             m_full = 0, m_ovf = 0, started = 0;

  always @(posedge clk) begin
    logic [W-1:0] wm, wl;
    bit complete, dropped;
    if (reset) begin
      bq.delete(); exp_m.delete(); exp_l.delete();
      m_full = 0; m_ovf = 0; m_wm = '0; m_wl = '0;
    end else begin
      complete = 0; dropped = 0; wm = '0; wl = '0;
      if (bv) begin
        bq.push_back(bi);
        if (bq.size() == W) begin
          complete = 1;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = bq[i];
            wl[i]     = bq[i];
          end
          bq.delete();
        end
      end
      if (complete) begin
        if (!m_full || rdy) begin
          m_full = 1; m_wm = wm; m_wl = wl;
          exp_m.push_back(wm); exp_l.push_back(wl);
        end else dropped = 1;
      end else if (m_full && rdy) m_full = 0;
      if (dropped) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    started = 1;
  end

  // Monitor: status every cycle; a word is popped whenever the DUT presents it with ready.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (started) begin
      chk("valid_m", {31'b0, if_m.word_valid}, {31'b0, m_full});
      chk("valid_l", {31'b0, if_l.word_valid}, {31'b0, m_full});
      chk("ovf_m", {31'b0, if_m.overflow}, {31'b0, m_ovf});
      chk("ovf_l", {31'b0, if_l.overflow}, {31'b0, m_ovf});
      chk("cnt_m", {29'b0, if_m.bit_cnt}, bq.size());
      chk("cnt_l", {29'b0, if_l.bit_cnt}, bq.size());
      if (m_full) begin
        chk("hold_m", {24'b0, if_m.word_out}, {24'b0, m_wm});
        chk("hold_l", {24'b0, if_l.word_out}, {24'b0, m_wl});
      end
      if (!reset && if_m.word_valid && rdy) begin
        if (exp_m.size() == 0) chk("pop_empty_m", 1, 0);
        else begin e = exp_m.pop_front(); chk("word_m", {24'b0, if_m.word_out}, {24'b0, e}); end
      end
      if (!reset && if_l.word_valid && rdy) begin
        if (exp_l.size() == 0) chk("pop_empty_l", 1, 0);
        else begin e = exp_l.pop_front(); chk("word_l", {24'b0, if_l.word_out}, {24'b0, e}); end
      end
    end
  end

  task automatic cyc(input logic v, input logic b);
    @(posedge clk); #1;
    bv = v; bi = b;
  endtask

  // Sends one word in the given bit order with up to gmax idle cycles before each bit.
  task automatic send(input logic [W-1:0] w, input bit msb, input int gmax);
    for (int i = 0; i < W; i++) begin
      int g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      for (int k = 0; k < g; k++) cyc(1'b0, 1'($urandom));
      cyc(1'b1, msb ? w[W-1-i] : w[i]);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] w22;
    idle(2);
    @(posedge clk); #1; reset = 0;
    chk("reset_word", {24'b0, if_m.word_out}, 0);
    // A5 MSB-first with ready high; 2D LSB-first
    rdy = 1;
    send(8'hA5, 1, 0); idle(2);
    send(8'h2D, 0, 0); idle(2);
    // Backpressure: second word dropped, then drain and clear
    rdy = 0;
    send(8'h3C, 1, 0); send(8'hC3, 1, 0); idle(3);
    rdy = 1; idle(1); rdy = 0; idle(2);
    @(posedge clk); #1; clr = 1;
    @(posedge clk); #1; clr = 0;
    // Back-to-back: ready arrives on the edge completing the second word
    send(8'h11, 1, 0);
    w22 = 8'h22;
    for (int i = 0; i < W; i++) begin
      cyc(1'b1, w22[W-1-i]);
      if (i == W - 1) rdy = 1;
    end
    cyc(1'b0, 1'b0); rdy = 1; idle(2);
    // Reset mid-word, then all ones
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    @(posedge clk); #1; bv = 0; reset = 1;
    @(posedge clk); #1; reset = 0;
    send(8'hFF, 1, 0); idle(2);
    // Random gaps with junk on bit_in while idle
    send(8'h5A, 1, 3); idle(2);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      bv    = ($urandom_range(99) < 60);
      bi    = 1'($urandom);
      rdy   = ($urandom_range(99) < 55);
      clr   = ($urandom_range(99) < 5);
      reset = ($urandom_range(999) < 5);
    end
    @(posedge clk); #1; reset = 0; bv = 0; clr = 0; rdy = 1;
    idle(4);
    chk("drain_m", exp_m.size(), 0);
    chk("drain_l", exp_l.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
